ac_goto_writer: RTL and testbench
=================================

# ac_goto_writer

Builds the Aho-Corasick goto table by trie insertion and writes it into the goto-table RAMs (current state, character, next state) that the table-reader side walks during matching. Keywords arrive one 4-bit character per handshake. Each character is resolved against the entries written so far: an existing edge is followed, otherwise a new state is allocated and an entry is appended. The failure table is out of scope and is produced by a separate block.

## Interface
Parameters:
- DEPTH, 32, number of goto entries (RAM depth)
- AW, 5, entry address width
- CHAR_W, 4, character width
- STATE_W, 8, state number width

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- CLR  in  1  synchronous table clear, priority over everything except RST
- IN_VALID  in  1  character valid
- IN_READY  out  1  block can accept a character
- IN_CHAR  in  CHAR_W  keyword character
- IN_LAST  in  1  qualifies IN_CHAR as final character of the keyword
- WR_EN  out  1  one-cycle write strobe to the goto RAMs
- WR_ADDR  out  AW  entry address
- WR_CUR  out  STATE_W  current-state field
- WR_CHARA  out  CHAR_W  character field
- WR_NEXT  out  STATE_W  next-state field
- MATCH_VALID  out  1  one-cycle pulse: keyword inserted
- MATCH_STATE  out  STATE_W  accepting state of that keyword
- ENTRY_COUNT  out  AW+1  entries written (0..DEPTH)
- STATE_COUNT  out  STATE_W  next state number to allocate
- ERR  out  1  sticky table overflow

## Operation
- Root is state 0. States are allocated 1, 2, 3, … in order.
- FSM states: IDLE, SCAN, APPEND, DROP.
- IDLE:
  - IN_READY = 1.
  - On IN_VALID: latch char and last, set idx = 0, go to SCAN.
- SCAN: one entry per cycle.
  - idx < ENTRY_COUNT and entry[idx] = {cur, char}: cur <= entry[idx].next, go to IDLE (hit).
  - idx < ENTRY_COUNT otherwise: idx++.
  - idx = ENTRY_COUNT: go to APPEND.
- APPEND:
  - If ENTRY_COUNT < DEPTH:
    - WR_EN = 1, WR_ADDR = ENTRY_COUNT, fields {cur, char, STATE_COUNT}.
    - Mirror the entry into the internal shadow store.
    - cur <= STATE_COUNT, STATE_COUNT++, ENTRY_COUNT++.
    - Go to IDLE.
  - If ENTRY_COUNT = DEPTH:
    - ERR <= 1, no write.
    - If latched last: cur <= 0, go to IDLE, no MATCH_VALID.
    - Else go to DROP.
- DROP:
  - IN_READY = 1.
  - Characters are accepted and discarded.
  - The IN_LAST character sets cur <= 0, returns to IDLE, and produces no MATCH_VALID.
- Keyword end (latched last, resolved by hit or successful APPEND):
  - MATCH_VALID pulses in the first following IDLE cycle, with MATCH_STATE = final cur.
  - cur <= 0.
- Duplicate keyword: all hits, no WR_EN, MATCH_STATE equals the earlier insertion's state.
- CLR in any state:
  - ENTRY_COUNT = 0, STATE_COUNT = 1, cur = 0, ERR = 0, go to IDLE.
  - Any in-flight character is dropped.
  - IN_READY = 0 during the CLR cycle.
- RST values:
  - IDLE, so IN_READY = 1 once out of reset.
  - WR_EN, MATCH_VALID, ERR, ENTRY_COUNT = 0.
  - All WR_* fields and MATCH_STATE = 0.
  - STATE_COUNT = 1.
  - Shadow store contents are don't-care; it is guarded by ENTRY_COUNT.

## Timing
- Let T be the accept cycle (IN_VALID & IN_READY).
- SCAN idx i is evaluated in cycle T+1+i.
- Hit at idx i: IN_READY high again in cycle T+2+i.
- Miss: SCAN runs T+1..T+1+n (n = ENTRY_COUNT), APPEND/WR_EN in T+2+n, IN_READY in T+3+n.
- Empty table: APPEND in T+2, IN_READY in T+3.
- MATCH_VALID is coincident with the IN_READY-return cycle. A new character can be accepted in that same cycle.
- IN_VALID/IN_CHAR/IN_LAST are sampled only when IN_READY = 1. A held IN_VALID is never double-consumed.
- DROP accepts one character per cycle.

## Structure
- Package ac_pkg holds:
  - DEPTH, AW, CHAR_W, STATE_W
  - ROOT_STATE = 0
  - the FSM state enum
  - the goto-entry struct {cur, chara, next}; reused by the table-reader and failure blocks
- Sub-module ac_entry_store:
  - DEPTH × entry register file
  - one synchronous write port and one combinational indexed read port
  - feeds SCAN compares

## Test plan
- Insert "he" (chars 1,2, last on 2) into an empty table:
  - writes addr0 {0,1,1} and addr1 {1,2,2}
  - MATCH_STATE = 2, ENTRY_COUNT = 2, STATE_COUNT = 3
- Then insert "hi" (1,3):
  - char 1 hits at idx0, IN_READY back at T+2
  - write addr2 {1,3,3}, MATCH_STATE = 3
- Re-insert "he": no WR_EN, MATCH_STATE = 2, counters unchanged.
- Backpressure: IN_VALID held high with a 3-character keyword during long scans → exactly 3 characters consumed and the correct entries written.
- Fill 32 distinct single-character-path entries, then a new edge with a 2-character keyword:
  - ERR = 1, no WR_EN
  - second character swallowed in DROP, no MATCH_VALID
  - the next keyword that fully hits existing entries still matches
- CLR asserted mid-SCAN, and RST asserted mid-APPEND:
  - ENTRY_COUNT = 0, STATE_COUNT = 1, ERR = 0, IN_READY = 1 afterwards
  - the next "he" writes again starting at addr0

Source files
------------

// File: rtl/ac_pkg.sv
// Shared constants and types for the Aho-Corasick table builders and readers.
// The goto-entry struct is the common record format of the goto RAMs.
package ac_pkg;

    localparam int DEPTH   = 32;
    localparam int AW      = 5;
    localparam int CHAR_W  = 4;
    localparam int STATE_W = 8;

    localparam logic [STATE_W-1:0] ROOT_STATE = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        APPEND = 2'd2,
        DROP   = 2'd3
    } ac_state_e;

    typedef struct packed {
        logic [STATE_W-1:0] cur;
        logic [CHAR_W-1:0]  chara;
        logic [STATE_W-1:0] next;
    } ac_entry_t;

endpackage

// File: rtl/ac_goto_writer_if.sv
// Character input handshake, goto RAM write port and status of the goto writer.
// master = keyword source / RAM owner, slave = the writer itself.
interface ac_goto_writer_if;
    import ac_pkg::*;

    logic               IN_VALID;
    logic               IN_READY;
    logic [CHAR_W-1:0]  IN_CHAR;
    logic               IN_LAST;

    logic               WR_EN;
    logic [AW-1:0]      WR_ADDR;
    logic [STATE_W-1:0] WR_CUR;
    logic [CHAR_W-1:0]  WR_CHARA;
    logic [STATE_W-1:0] WR_NEXT;

    logic               MATCH_VALID;
    logic [STATE_W-1:0] MATCH_STATE;
    logic [AW:0]        ENTRY_COUNT;
    logic [STATE_W-1:0] STATE_COUNT;
    logic               ERR;

    modport master (
        output IN_VALID, IN_CHAR, IN_LAST,
        input  IN_READY, WR_EN, WR_ADDR, WR_CUR, WR_CHARA, WR_NEXT,
        input  MATCH_VALID, MATCH_STATE, ENTRY_COUNT, STATE_COUNT, ERR
    );

    modport slave (
        input  IN_VALID, IN_CHAR, IN_LAST,
        output IN_READY, WR_EN, WR_ADDR, WR_CUR, WR_CHARA, WR_NEXT,
        output MATCH_VALID, MATCH_STATE, ENTRY_COUNT, STATE_COUNT, ERR
    );

endinterface

// File: rtl/ac_entry_store.sv
// Shadow copy of the goto entries written so far, read combinationally by SCAN.
// Left unreset on purpose: only entries below ENTRY_COUNT are ever trusted.
module ac_entry_store
    import ac_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  ac_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output ac_entry_t     rdata
);

    ac_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ac_goto_writer.sv
// Trie-insertion builder of the Aho-Corasick goto table: resolves each keyword
// character against the existing entries and appends a new state on a miss.
module ac_goto_writer
    import ac_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    ac_goto_writer_if.slave  bus
);

    localparam logic [AW:0]        ENTRY_MAX   = (AW+1)'(DEPTH);
    localparam logic [STATE_W-1:0] FIRST_STATE = STATE_W'(1);

    ac_state_e          state, state_d;
    logic [STATE_W-1:0] cur, cur_d;
    logic [CHAR_W-1:0]  chr_q, chr_d;
    logic               last_q, last_d;
    logic [AW:0]        idx, idx_d;
    logic [AW:0]        entry_count, entry_count_d;
    logic [STATE_W-1:0] state_count, state_count_d;
    logic               err, err_d;
    logic               match_pend, match_pend_d;
    logic [STATE_W-1:0] match_q, match_d;

    logic               in_ready;
    logic               we;
    logic               match_valid;
    logic               resolve;
    logic [STATE_W-1:0] resolved_state;

    ac_entry_t          rd_entry;
    ac_entry_t          wr_entry;
    logic               scan_done;
    logic               scan_hit;
    logic               table_full;

    assign wr_entry   = '{cur: cur, chara: chr_q, next: state_count};
    assign scan_done  = (idx == entry_count);
    assign scan_hit   = !scan_done && (rd_entry.cur == cur) && (rd_entry.chara == chr_q);
    assign table_full = (entry_count == ENTRY_MAX);

    ac_entry_store u_store (
        .clk   (CLK),
        .we    (we),
        .waddr (entry_count[AW-1:0]),
        .wdata (wr_entry),
        .raddr (idx[AW-1:0]),
        .rdata (rd_entry)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            cur         <= ROOT_STATE;
            chr_q       <= '0;
            last_q      <= 1'b0;
            idx         <= '0;
            entry_count <= '0;
            state_count <= FIRST_STATE;
            err         <= 1'b0;
            match_pend  <= 1'b0;
            match_q     <= ROOT_STATE;
        end else begin
            state       <= state_d;
            cur         <= cur_d;
            chr_q       <= chr_d;
            last_q      <= last_d;
            idx         <= idx_d;
            entry_count <= entry_count_d;
            state_count <= state_count_d;
            err         <= err_d;
            match_pend  <= match_pend_d;
            match_q     <= match_d;
        end
    end

    // A completed keyword parks its accepting state in match_q and announces it
    // in the next IDLE cycle, so the walk can restart from root immediately.
    always_comb begin
        state_d        = state;
        cur_d          = cur;
        chr_d          = chr_q;
        last_d         = last_q;
        idx_d          = idx;
        entry_count_d  = entry_count;
        state_count_d  = state_count;
        err_d          = err;
        match_pend_d   = match_pend;
        match_d        = match_q;
        in_ready       = 1'b0;
        we             = 1'b0;
        match_valid    = 1'b0;
        resolve        = 1'b0;
        resolved_state = ROOT_STATE;

        if (CLR) begin
            state_d       = IDLE;
            cur_d         = ROOT_STATE;
            idx_d         = '0;
            entry_count_d = '0;
            state_count_d = FIRST_STATE;
            err_d         = 1'b0;
            match_pend_d  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready = 1'b1;
                    if (match_pend) begin
                        match_valid  = 1'b1;
                        match_pend_d = 1'b0;
                    end
                    if (bus.IN_VALID) begin
                        chr_d   = bus.IN_CHAR;
                        last_d  = bus.IN_LAST;
                        idx_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (scan_done) begin
                        state_d = APPEND;
                    end else if (scan_hit) begin
                        resolve        = 1'b1;
                        resolved_state = rd_entry.next;
                    end else begin
                        idx_d = idx + (AW+1)'(1);
                    end
                end
                APPEND: begin
                    if (!table_full) begin
                        we             = 1'b1;
                        resolve        = 1'b1;
                        resolved_state = state_count;
                        state_count_d  = state_count + FIRST_STATE;
                        entry_count_d  = entry_count + (AW+1)'(1);
                    end else begin
                        err_d = 1'b1;
                        if (last_q) begin
                            cur_d   = ROOT_STATE;
                            state_d = IDLE;
                        end else begin
                            state_d = DROP;
                        end
                    end
                end
                DROP: begin
                    in_ready = 1'b1;
                    if (bus.IN_VALID && bus.IN_LAST) begin
                        cur_d   = ROOT_STATE;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (resolve) begin
                state_d = IDLE;
                if (last_q) begin
                    cur_d        = ROOT_STATE;
                    match_d      = resolved_state;
                    match_pend_d = 1'b1;
                end else begin
                    cur_d = resolved_state;
                end
            end
        end
    end

    assign bus.IN_READY    = in_ready;
    assign bus.WR_EN       = we;
    assign bus.WR_ADDR     = we ? entry_count[AW-1:0] : '0;
    assign bus.WR_CUR      = we ? cur : '0;
    assign bus.WR_CHARA    = we ? chr_q : '0;
    assign bus.WR_NEXT     = we ? state_count : '0;
    assign bus.MATCH_VALID = match_valid;
    assign bus.MATCH_STATE = match_valid ? match_q : ROOT_STATE;
    assign bus.ENTRY_COUNT = entry_count;
    assign bus.STATE_COUNT = state_count;
    assign bus.ERR         = err;

endmodule

// File: tb/tb_ac_goto_writer.sv
// Directed bench for ac_goto_writer: insertion, hits, duplicates, held IN_VALID,
// overflow/DROP, CLR mid-SCAN and reset mid-APPEND, with hand-computed entries.
module tb_ac_goto_writer;
    import ac_pkg::*;

    logic CLK;
    logic RST;
    logic CLR;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int match_cnt = 0;
    int acc_cnt   = 0;
    logic [STATE_W-1:0] match_last = '0;
    logic [AW+2*STATE_W+CHAR_W-1:0] wq [$];

    ac_goto_writer_if bus();

    ac_goto_writer dut (
        .CLK (CLK),
        .RST (RST),
        .CLR (CLR),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Log every write, match and accepted character mid-cycle, away from edges.
    always @(negedge CLK) begin
        if (bus.WR_EN === 1'b1) wq.push_back({bus.WR_ADDR, bus.WR_CUR, bus.WR_CHARA, bus.WR_NEXT});
        if (bus.MATCH_VALID === 1'b1) begin
            match_cnt  = match_cnt + 1;
            match_last = bus.MATCH_STATE;
        end
        if (bus.IN_VALID === 1'b1 && bus.IN_READY === 1'b1) acc_cnt = acc_cnt + 1;
    end

    task automatic send_char(input logic [CHAR_W-1:0] c, input logic l, output int t_acc);
        t_acc = -1;
        bus.IN_VALID = 1'b1;
        bus.IN_CHAR  = c;
        bus.IN_LAST  = l;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (bus.IN_READY === 1'b1) begin
                t_acc = cyc;
                break;
            end
        end
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        checks++;
        if (t_acc < 0) begin failures++; $display("[TB] FAIL accept_timeout got=no_accept exp=accept_within_200"); end
    endtask

    task automatic wait_ready(output int t_rdy);
        t_rdy = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (bus.IN_READY === 1'b1) begin
                t_rdy = cyc;
                break;
            end
        end
        @(posedge CLK); #1;
        checks++;
        if (t_rdy < 0) begin failures++; $display("[TB] FAIL ready_timeout got=no_ready exp=ready_within_200"); end
    endtask

    task automatic test_reset();
        RST = 1'b0; CLR = 1'b0;
        bus.IN_VALID = 1'b0; bus.IN_CHAR = '0; bus.IN_LAST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (bus.WR_EN !== 1'b0) begin failures++; $display("[TB] FAIL rst_wr_en got=%0b exp=0", bus.WR_EN); end
        checks++; if (bus.MATCH_VALID !== 1'b0) begin failures++; $display("[TB] FAIL rst_match_valid got=%0b exp=0", bus.MATCH_VALID); end
        checks++; if (bus.ERR !== 1'b0) begin failures++; $display("[TB] FAIL rst_err got=%0b exp=0", bus.ERR); end
        checks++; if (bus.ENTRY_COUNT !== 6'd0) begin failures++; $display("[TB] FAIL rst_entry_count got=%0d exp=0", bus.ENTRY_COUNT); end
        checks++; if (bus.STATE_COUNT !== 8'd1) begin failures++; $display("[TB] FAIL rst_state_count got=%0d exp=1", bus.STATE_COUNT); end
        checks++; if (bus.WR_NEXT !== 8'd0 || bus.WR_ADDR !== 5'd0) begin failures++; $display("[TB] FAIL rst_wr_fields got=%0d/%0d exp=0/0", bus.WR_ADDR, bus.WR_NEXT); end
        checks++; if (bus.MATCH_STATE !== 8'd0) begin failures++; $display("[TB] FAIL rst_match_state got=%0d exp=0", bus.MATCH_STATE); end
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (bus.IN_READY !== 1'b1) begin failures++; $display("[TB] FAIL rst_in_ready got=%0b exp=1", bus.IN_READY); end
        @(posedge CLK); #1;
    endtask

    task automatic test_insert_he();
        int t1, t2, t3, m0;
        wq.delete(); m0 = match_cnt;
        send_char(4'd1, 1'b0, t1);
        send_char(4'd2, 1'b1, t2);
        wait_ready(t3);
        @(posedge CLK); #1;
        checks++; if (t2 - t1 != 3) begin failures++; $display("[TB] FAIL he_empty_latency got=%0d exp=3", t2 - t1); end
        checks++; if (t3 - t2 != 4) begin failures++; $display("[TB] FAIL he_miss1_latency got=%0d exp=4", t3 - t2); end
        checks++; if (wq.size() != 2) begin failures++; $display("[TB] FAIL he_write_count got=%0d exp=2", wq.size()); end
        checks++; if (wq[0] !== {5'd0, 8'd0, 4'd1, 8'd1}) begin failures++; $display("[TB] FAIL he_entry0 got=%h exp=%h", wq[0], {5'd0, 8'd0, 4'd1, 8'd1}); end
        checks++; if (wq[1] !== {5'd1, 8'd1, 4'd2, 8'd2}) begin failures++; $display("[TB] FAIL he_entry1 got=%h exp=%h", wq[1], {5'd1, 8'd1, 4'd2, 8'd2}); end
        checks++; if (match_cnt - m0 != 1 || match_last !== 8'd2) begin failures++; $display("[TB] FAIL he_match got=%0d@%0d exp=1@2", match_cnt - m0, match_last); end
        checks++; if (bus.ENTRY_COUNT !== 6'd2 || bus.STATE_COUNT !== 8'd3) begin failures++; $display("[TB] FAIL he_counts got=%0d/%0d exp=2/3", bus.ENTRY_COUNT, bus.STATE_COUNT); end
    endtask

    task automatic test_insert_hi();
        int t1, t2, t3, m0;
        wq.delete(); m0 = match_cnt;
        send_char(4'd1, 1'b0, t1);
        send_char(4'd3, 1'b1, t2);
        wait_ready(t3);
        @(posedge CLK); #1;
        checks++; if (t2 - t1 != 2) begin failures++; $display("[TB] FAIL hi_hit_latency got=%0d exp=2", t2 - t1); end
        checks++; if (t3 - t2 != 5) begin failures++; $display("[TB] FAIL hi_miss_latency got=%0d exp=5", t3 - t2); end
        checks++; if (wq.size() != 1 || wq[0] !== {5'd2, 8'd1, 4'd3, 8'd3}) begin failures++; $display("[TB] FAIL hi_entry2 got=%h n=%0d exp=%h n=1", wq[0], wq.size(), {5'd2, 8'd1, 4'd3, 8'd3}); end
        checks++; if (match_cnt - m0 != 1 || match_last !== 8'd3) begin failures++; $display("[TB] FAIL hi_match got=%0d@%0d exp=1@3", match_cnt - m0, match_last); end
        checks++; if (bus.ENTRY_COUNT !== 6'd3 || bus.STATE_COUNT !== 8'd4) begin failures++; $display("[TB] FAIL hi_counts got=%0d/%0d exp=3/4", bus.ENTRY_COUNT, bus.STATE_COUNT); end
    endtask

    task automatic test_duplicate();
        int t1, t2, t3, m0;
        wq.delete(); m0 = match_cnt;
        send_char(4'd1, 1'b0, t1);
        send_char(4'd2, 1'b1, t2);
        wait_ready(t3);
        @(posedge CLK); #1;
        checks++; if (t3 - t2 != 3) begin failures++; $display("[TB] FAIL dup_hit1_latency got=%0d exp=3", t3 - t2); end
        checks++; if (wq.size() != 0) begin failures++; $display("[TB] FAIL dup_no_write got=%0d exp=0", wq.size()); end
        checks++; if (match_cnt - m0 != 1 || match_last !== 8'd2) begin failures++; $display("[TB] FAIL dup_match got=%0d@%0d exp=1@2", match_cnt - m0, match_last); end
        checks++; if (bus.ENTRY_COUNT !== 6'd3 || bus.STATE_COUNT !== 8'd4) begin failures++; $display("[TB] FAIL dup_counts got=%0d/%0d exp=3/4", bus.ENTRY_COUNT, bus.STATE_COUNT); end
    endtask

    task automatic test_back_to_back();
        int t1, t2, t3, t4, m0, a0;
        wq.delete(); m0 = match_cnt; a0 = acc_cnt;
        send_char(4'd5, 1'b0, t1);
        send_char(4'd6, 1'b0, t2);
        send_char(4'd7, 1'b1, t3);
        wait_ready(t4);
        @(posedge CLK); #1;
        checks++; if (acc_cnt - a0 != 3) begin failures++; $display("[TB] FAIL b2b_accepts got=%0d exp=3", acc_cnt - a0); end
        checks++; if (t2 - t1 != 6) begin failures++; $display("[TB] FAIL b2b_miss3_latency got=%0d exp=6", t2 - t1); end
        checks++; if (wq.size() != 3) begin failures++; $display("[TB] FAIL b2b_write_count got=%0d exp=3", wq.size()); end
        checks++; if (wq[0] !== {5'd3, 8'd0, 4'd5, 8'd4}) begin failures++; $display("[TB] FAIL b2b_entry3 got=%h exp=%h", wq[0], {5'd3, 8'd0, 4'd5, 8'd4}); end
        checks++; if (wq[1] !== {5'd4, 8'd4, 4'd6, 8'd5}) begin failures++; $display("[TB] FAIL b2b_entry4 got=%h exp=%h", wq[1], {5'd4, 8'd4, 4'd6, 8'd5}); end
        checks++; if (wq[2] !== {5'd5, 8'd5, 4'd7, 8'd6}) begin failures++; $display("[TB] FAIL b2b_entry5 got=%h exp=%h", wq[2], {5'd5, 8'd5, 4'd7, 8'd6}); end
        checks++; if (match_cnt - m0 != 1 || match_last !== 8'd6) begin failures++; $display("[TB] FAIL b2b_match got=%0d@%0d exp=1@6", match_cnt - m0, match_last); end
    endtask

    task automatic test_clr_mid_scan();
        int t1, t2, t3, m0;
        wq.delete();
        send_char(4'd9, 1'b0, t1);
        @(posedge CLK); #1;
        CLR = 1'b1;
        @(negedge CLK);
        checks++; if (bus.IN_READY !== 1'b0) begin failures++; $display("[TB] FAIL clr_in_ready_low got=%0b exp=0", bus.IN_READY); end
        @(posedge CLK); #1;
        CLR = 1'b0;
        @(negedge CLK);
        checks++; if (bus.IN_READY !== 1'b1) begin failures++; $display("[TB] FAIL clr_in_ready_high got=%0b exp=1", bus.IN_READY); end
        checks++; if (bus.ENTRY_COUNT !== 6'd0 || bus.STATE_COUNT !== 8'd1 || bus.ERR !== 1'b0) begin failures++; $display("[TB] FAIL clr_counts got=%0d/%0d/%0b exp=0/1/0", bus.ENTRY_COUNT, bus.STATE_COUNT, bus.ERR); end
        checks++; if (wq.size() != 0) begin failures++; $display("[TB] FAIL clr_dropped_char got=%0d exp=0", wq.size()); end
        @(posedge CLK); #1;
        m0 = match_cnt;
        send_char(4'd1, 1'b0, t1);
        send_char(4'd2, 1'b1, t2);
        wait_ready(t3);
        @(posedge CLK); #1;
        checks++; if (wq.size() != 2 || wq[0] !== {5'd0, 8'd0, 4'd1, 8'd1} || wq[1] !== {5'd1, 8'd1, 4'd2, 8'd2}) begin failures++; $display("[TB] FAIL clr_he_rewrite got=%h,%h n=%0d exp=%h,%h n=2", wq[0], wq[1], wq.size(), {5'd0, 8'd0, 4'd1, 8'd1}, {5'd1, 8'd1, 4'd2, 8'd2}); end
        checks++; if (match_cnt - m0 != 1 || match_last !== 8'd2) begin failures++; $display("[TB] FAIL clr_he_match got=%0d@%0d exp=1@2", match_cnt - m0, match_last); end
    endtask

    task automatic test_overflow();
        int t1, t2, t3, m0, a0;
        wq.delete(); m0 = match_cnt;
        for (int i = 0; i < 30; i++) send_char(4'd4, (i == 29), t1);
        wait_ready(t3);
        @(posedge CLK); #1;
        checks++; if (wq.size() != 30) begin failures++; $display("[TB] FAIL fill_write_count got=%0d exp=30", wq.size()); end
        checks++; if (wq[0] !== {5'd2, 8'd0, 4'd4, 8'd3}) begin failures++; $display("[TB] FAIL fill_first got=%h exp=%h", wq[0], {5'd2, 8'd0, 4'd4, 8'd3}); end
        checks++; if (wq[29] !== {5'd31, 8'd31, 4'd4, 8'd32}) begin failures++; $display("[TB] FAIL fill_last got=%h exp=%h", wq[29], {5'd31, 8'd31, 4'd4, 8'd32}); end
        checks++; if (match_cnt - m0 != 1 || match_last !== 8'd32) begin failures++; $display("[TB] FAIL fill_match got=%0d@%0d exp=1@32", match_cnt - m0, match_last); end
        checks++; if (bus.ENTRY_COUNT !== 6'd32 || bus.STATE_COUNT !== 8'd33 || bus.ERR !== 1'b0) begin failures++; $display("[TB] FAIL fill_counts got=%0d/%0d/%0b exp=32/33/0", bus.ENTRY_COUNT, bus.STATE_COUNT, bus.ERR); end
        wq.delete(); m0 = match_cnt; a0 = acc_cnt;
        send_char(4'd9, 1'b0, t1);
        send_char(4'd9, 1'b1, t2);
        wait_ready(t3);
        @(posedge CLK); #1;
        checks++; if (t2 - t1 != 35) begin failures++; $display("[TB] FAIL ovf_drop_latency got=%0d exp=35", t2 - t1); end
        checks++; if (t3 - t2 != 1) begin failures++; $display("[TB] FAIL ovf_drop_exit got=%0d exp=1", t3 - t2); end
        checks++; if (bus.ERR !== 1'b1) begin failures++; $display("[TB] FAIL ovf_err got=%0b exp=1", bus.ERR); end
        checks++; if (wq.size() != 0) begin failures++; $display("[TB] FAIL ovf_no_write got=%0d exp=0", wq.size()); end
        checks++; if (match_cnt != m0) begin failures++; $display("[TB] FAIL ovf_no_match got=%0d exp=0", match_cnt - m0); end
        checks++; if (acc_cnt - a0 != 2 || bus.ENTRY_COUNT !== 6'd32) begin failures++; $display("[TB] FAIL ovf_accepts got=%0d/%0d exp=2/32", acc_cnt - a0, bus.ENTRY_COUNT); end
        m0 = match_cnt;
        send_char(4'd1, 1'b0, t1);
        send_char(4'd2, 1'b1, t2);
        wait_ready(t3);
        @(posedge CLK); #1;
        checks++; if (match_cnt - m0 != 1 || match_last !== 8'd2 || wq.size() != 0) begin failures++; $display("[TB] FAIL ovf_he_hit got=%0d@%0d w=%0d exp=1@2 w=0", match_cnt - m0, match_last, wq.size()); end
        checks++; if (bus.ERR !== 1'b1) begin failures++; $display("[TB] FAIL ovf_err_sticky got=%0b exp=1", bus.ERR); end
    endtask

    task automatic test_clr_after_overflow();
        CLR = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
        @(negedge CLK);
        checks++; if (bus.ERR !== 1'b0 || bus.ENTRY_COUNT !== 6'd0 || bus.STATE_COUNT !== 8'd1) begin failures++; $display("[TB] FAIL clr_err got=%0b/%0d/%0d exp=0/0/1", bus.ERR, bus.ENTRY_COUNT, bus.STATE_COUNT); end
        @(posedge CLK); #1;
    endtask

    task automatic test_rst_mid_append();
        int t1, t2, t3, m0;
        send_char(4'd1, 1'b0, t1);
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++; if (bus.WR_EN !== 1'b1 || bus.WR_ADDR !== 5'd0) begin failures++; $display("[TB] FAIL rst_append_strobe got=%0b@%0d exp=1@0", bus.WR_EN, bus.WR_ADDR); end
        #1 RST = 1'b0;
        #1;
        checks++; if (bus.WR_EN !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_wr_en got=%0b exp=0", bus.WR_EN); end
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (bus.ENTRY_COUNT !== 6'd0 || bus.STATE_COUNT !== 8'd1 || bus.ERR !== 1'b0 || bus.IN_READY !== 1'b1) begin failures++; $display("[TB] FAIL rst_after_append got=%0d/%0d/%0b/%0b exp=0/1/0/1", bus.ENTRY_COUNT, bus.STATE_COUNT, bus.ERR, bus.IN_READY); end
        @(posedge CLK); #1;
        wq.delete(); m0 = match_cnt;
        send_char(4'd1, 1'b0, t1);
        send_char(4'd2, 1'b1, t2);
        wait_ready(t3);
        @(posedge CLK); #1;
        checks++; if (wq.size() != 2 || wq[0] !== {5'd0, 8'd0, 4'd1, 8'd1} || wq[1] !== {5'd1, 8'd1, 4'd2, 8'd2}) begin failures++; $display("[TB] FAIL rst_he_rewrite got=%h,%h n=%0d exp=%h,%h n=2", wq[0], wq[1], wq.size(), {5'd0, 8'd0, 4'd1, 8'd1}, {5'd1, 8'd1, 4'd2, 8'd2}); end
        checks++; if (match_cnt - m0 != 1 || match_last !== 8'd2) begin failures++; $display("[TB] FAIL rst_he_match got=%0d@%0d exp=1@2", match_cnt - m0, match_last); end
    endtask

    initial begin
        test_reset();
        test_insert_he();
        test_insert_hi();
        test_duplicate();
        test_back_to_back();
        test_clr_mid_scan();
        test_overflow();
        test_clr_after_overflow();
        test_rst_mid_append();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
